// File: rtl/noc_pkg.sv
// Shared NoC router types and helpers.
// Used by the output arbiter and the crossbar input-side arbiter.
package noc_pkg;

  localparam int NUM_PORTS = 4;
  localparam int MAX_PORTS = 32;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Rotate a one-hot vector up by one, wrapping at bit n-1.
  function automatic logic [MAX_PORTS-1:0] rr_rotate_next(
    input logic [MAX_PORTS-1:0] onehot,
    input int                   n
  );
    logic [MAX_PORTS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n && onehot[i]) begin
        if (i == n - 1) r[0] = 1'b1;
        else            r[i+1] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_output_arbiter_if.sv
// Request/grant bundle between input buffers and the output arbiter.
// master: input-buffer side, slave: arbiter side.
interface rr_output_arbiter_if #(
  parameter int N = 4
) ();

  logic [N-1:0] req_i;
  logic [N-1:0] tail_i;
  logic         out_ready_i;
  logic [N-1:0] gnt_o;
  logic         out_valid_o;
  logic         locked_o;
  logic [N-1:0] priority_order_o;
  logic         timeout_o;

  modport master (
    output req_i, tail_i, out_ready_i,
    input  gnt_o, out_valid_o, locked_o,
    input  priority_order_o, timeout_o
  );

  modport slave (
    input  req_i, tail_i, out_ready_i,
    output gnt_o, out_valid_o, locked_o,
    output priority_order_o, timeout_o
  );

endinterface

// File: rtl/rr_pick.sv
// One-hot circular priority picker: first set req bit at or above prio,
// wrapping to bit 0. Shared with the crossbar input-side arbiter.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] low;

  // Lower copy masked below prio, upper copy gives the wrapped scan.
  assign dbl = {req, req} & ~({{N{1'b0}}, prio} - 1'b1);
  assign low = dbl & (~dbl + 1'b1);
  assign gnt = low[N-1:0] | low[2*N-1:N];

endmodule

// File: rtl/rr_output_arbiter.sv
// Packet-granular round-robin arbiter for one NoC router output link.
// Optional stall watchdog: define RR_ARB_WATCHDOG_EN.
module rr_output_arbiter #(
  parameter int NUM_PORTS      = noc_pkg::NUM_PORTS,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  rr_output_arbiter_if.slave  bus
);

  import noc_pkg::*;

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("rr_output_arbiter: bad parameters");
  end

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] prio_q, prio_d;
  logic [NUM_PORTS-1:0] prio_rot;
  logic [NUM_PORTS-1:0] pick_prio;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic                 xfer, done, expire, rel;

  assign xfer = (|(gnt_q & bus.req_i)) & bus.out_ready_i;
  assign done = xfer & (|(gnt_q & bus.tail_i));
  assign rel  = (state_q == ARB_LOCKED) & (done | expire);

  assign prio_rot =
    NUM_PORTS'(rr_rotate_next(MAX_PORTS'(gnt_q), NUM_PORTS));
  // On release the old winner lands at lowest priority.
  assign pick_prio = rel ? prio_rot : prio_q;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req  (bus.req_i),
    .prio (pick_prio),
    .gnt  (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    unique case (1'b1)
      (state_q == ARB_IDLE): begin
        if (|bus.req_i) begin
          gnt_d   = pick_gnt;
          state_d = ARB_LOCKED;
        end
      end
      rel: begin
        prio_d  = prio_rot;
        gnt_d   = pick_gnt;
        state_d = (|pick_gnt) ? ARB_LOCKED : ARB_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      prio_q  <= NUM_PORTS'(1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end

`ifdef RR_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  always_comb begin
    cnt_d  = '0;
    expire = 1'b0;
    if (state_q == ARB_LOCKED && !xfer) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) expire = 1'b1;
      else                                  cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= expire;
    end
  end

  assign bus.timeout_o = tmo_q;
`else
  assign expire        = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.gnt_o            = gnt_q;
  assign bus.out_valid_o      = |(gnt_q & bus.req_i);
  assign bus.locked_o         = (state_q == ARB_LOCKED);
  assign bus.priority_order_o = prio_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Scoreboard bench for rr_output_arbiter (4 ports, timeout 16).
// Expectations are queued at drive time and popped after each edge.
module tb_rr_output_arbiter;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       lock;
    logic [3:0] prio;
    logic       tmo;
    logic       valid;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;
  exp_t sb[$];

  rr_output_arbiter_if #(.N(4)) bus ();

  rr_output_arbiter #(
    .NUM_PORTS      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] req,
                      input logic [3:0] tail, input logic rdy,
                      input logic [3:0] egnt, input logic elock,
                      input logic [3:0] eprio, input logic etmo);
    exp_t e;
    @(negedge clk);
    bus.req_i       = req;
    bus.tail_i      = tail;
    bus.out_ready_i = rdy;
    e.tag   = tag;
    e.gnt   = egnt;
    e.lock  = elock;
    e.prio  = eprio;
    e.tmo   = etmo;
    e.valid = |(egnt & req);
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".gnt"},   32'(bus.gnt_o),            32'(e.gnt));
      check({e.tag, ".lock"},  32'(bus.locked_o),         32'(e.lock));
      check({e.tag, ".prio"},  32'(bus.priority_order_o), 32'(e.prio));
      check({e.tag, ".tmo"},   32'(bus.timeout_o),        32'(e.tmo));
      check({e.tag, ".valid"}, 32'(bus.out_valid_o),      32'(e.valid));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, ".gnt"},   32'(bus.gnt_o),            32'h0);
    check({tag, ".lock"},  32'(bus.locked_o),         32'h0);
    check({tag, ".prio"},  32'(bus.priority_order_o), 32'h1);
    check({tag, ".tmo"},   32'(bus.timeout_o),        32'h0);
    check({tag, ".valid"}, 32'(bus.out_valid_o),      32'h0);
  endtask

  initial begin
    n_checks        = 0;
    n_errs          = 0;
    reset           = 1'b0;
    bus.req_i       = 4'b0000;
    bus.tail_i      = 4'b0000;
    bus.out_ready_i = 1'b1;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Port 1 wins from prio 0; 3-flit packet, then port 3 with no gap.
    step("p1_grant", 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001, 1'b0);
    step("p1_flit1", 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001, 1'b0);
    step("p1_flit2", 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001, 1'b0);
    step("p1_tail",  4'b1010, 4'b0010, 1'b1, 4'b1000, 1'b1, 4'b0100, 1'b0);
    // Sole requester re-granted at lowest priority.
    step("p3_solo",  4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'b0001, 1'b0);
    step("p3_bubble",4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0001, 1'b0);

    // Asynchronous reset mid-packet.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b1;

    // Single-flit packets from all ports rotate every cycle.
    step("rr_0", 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0);
    step("rr_1", 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
    step("rr_2", 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0);
    step("rr_3", 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0);
    step("rr_4", 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0);
    step("rr_5", 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
    step("rr_6", 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0);

    // Backpressure on port 2's tail while port 0 waits.
    for (int i = 0; i < 5; i++)
      step("stall", 4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0);
    step("stall_rel", 4'b0101, 4'b0100, 1'b1, 4'b0001, 1'b1, 4'b1000, 1'b0);

    // Lock port 1, last transfer, then it goes silent.
    step("wd_p1",   4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
    step("wd_flit", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
`ifdef RR_ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++)
      step("wd_wait", 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
    step("wd_fire",  4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1);
    step("wd_idle",  4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0);
    step("wd_regnt", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0100, 1'b0);
`else
    for (int i = 0; i < 17; i++)
      step("wd_hold", 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
    step("wd_still", 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0);
`endif

    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

Round-robin output-port arbiter for the NoC router. It shares one router output link between NUM_PORTS input ports. Each grant is held for a whole packet, from the head flit through the tail flit. When the packet finishes, the priority moves to the port after the winner, so every requester is served within NUM_PORTS packets. It sits between the input buffers and the output crossbar mux and drives the crossbar select with `gnt_o`.

## Interface
- NUM_PORTS, 4, number of requesting input ports (≥2)
- TIMEOUT_CYCLES, 16, stall limit used only when the watchdog is compiled in (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_i  in  NUM_PORTS  per-port flit-valid request
- tail_i  in  NUM_PORTS  per-port "current flit is tail"; a single-flit packet asserts it on its only flit
- out_ready_i  in  1  downstream link can accept a flit this cycle
- gnt_o  out  NUM_PORTS  registered one-hot grant (crossbar select); 0 when idle
- out_valid_o  out  1  combinational, `|(gnt_o & req_i)`
- locked_o  out  1  registered, 1 while a packet owns the link
- priority_order_o  out  NUM_PORTS  registered one-hot current highest-priority port
- timeout_o  out  1  registered one-cycle pulse when the watchdog releases a lock

## Operation
- Transfer: `xfer = |(gnt_o & req_i) & out_ready_i`. `done = xfer & |(gnt_o & tail_i)`.
- Pick function (combinational): scan `req_i` circularly, starting at the set bit of `priority_order_o` and moving upward with wrap (3→0). The first set bit wins.
- State IDLE (`locked_o=0`, `gnt_o=0`):
  - If `|req_i`, register `gnt_o = pick(req_i)` and go to LOCKED.
  - Otherwise stay in IDLE.
- State LOCKED: `gnt_o` holds. `req_i` and `tail_i` of other ports are ignored.
  - On `done` with winner w, set `priority_order_o = onehot((w+1) mod NUM_PORTS)`.
  - In the same cycle, pick among `req_i` using that new priority. Port w is included at lowest priority.
  - If the pick is nonzero, register the new grant and stay in LOCKED. This gives back-to-back packets with no bubble.
  - If the pick is zero, go to IDLE.
- `priority_order_o` changes only on `done` or on a timeout release. It never changes in IDLE.
- Winner deasserting `req_i` mid-packet (a bubble): the lock is held and `out_valid_o` = 0.
- `out_ready_i=0`: the lock is held and the flit is not consumed. Grant and priority are unchanged.

## Timing
- Reset values: `gnt_o=0`, `locked_o=0`, `priority_order_o = 1` (port 0 highest), `timeout_o=0`, watchdog counter 0, state IDLE.
- Reset assertion takes effect immediately (asynchronous), including mid-packet. The packet is abandoned and priority returns to port 0.
- Grant latency: `req_i` seen in IDLE at edge k gives `gnt_o` valid after edge k+1 (1 cycle).
- Re-arbitration on tail: the tail is transferred at edge k and the new grant is visible after edge k+1, so there are 0 idle cycles between packets.
- At most one bit of `gnt_o` and of `priority_order_o` is set, always.

## Configuration
- `RR_ARB_WATCHDOG_EN` defined:
  - In LOCKED, a counter increments on every cycle with no `xfer` and clears on `xfer`.
  - When it reaches TIMEOUT_CYCLES−1 without a transfer, the lock is released exactly as on `done`: priority rotates past w and the next pick is made the same cycle.
  - `timeout_o` pulses for 1 cycle and the counter clears.
- Not defined: no counter is built, the lock is held indefinitely, and `timeout_o` is tied to 0. The port is always present.

## Structure
- Shared package `noc_pkg`: `NUM_PORTS` default constant, `arb_state_t` enum {ARB_IDLE, ARB_LOCKED}, and the function `rr_rotate_next(onehot)` that rotates one-hot priority.
- One sub-module `rr_pick`: combinational one-hot circular priority picker. Inputs are `req` and `prio`; output is `gnt`. It is reused by the crossbar input-side arbiter.

## Test plan
- Reset, then `req_i=4'b1010` with `out_ready_i=1` → after 1 cycle `gnt_o=4'b0010` and `locked_o=1`. Tail on the 3rd flit → `priority_order_o=4'b0100`, `gnt_o=4'b1000` the next cycle with no gap.
- All four ports request continuously with 1-flit packets (`tail_i=4'b1111`) → grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Locked on port 2 with `out_ready_i=0` for 5 cycles and port 0 requesting → `gnt_o` stays `4'b0100` and priority is unchanged. After release, the tail transfer gives `gnt_o=4'b0001`.
- Assert reset low asynchronously mid-packet (`gnt_o=4'b1000`) → all outputs go to reset values before the next edge; the first grant after release goes to port 0 if it is requesting.
- With `RR_ARB_WATCHDOG_EN` and TIMEOUT_CYCLES=16, lock port 1 and then drop `req_i[1]` → `timeout_o` pulses 16 cycles after the last transfer and `priority_order_o=4'b0100`. Without the macro, port 1 stays locked and `timeout_o=0`.
- Winner port 3 tail transfer while only port 3 still requests → regranted to port 3 (lowest priority, sole requester) and `priority_order_o=4'b0001`.
